// File: rtl/instr_fetch_queue_pkg.sv
// Shared processor constants and the fetch-queue entry layout.
package instr_fetch_queue_pkg;
  localparam int PC_W    = 12;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch step; the 12-bit add wraps FFC -> 000 on its own.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO with synchronous flush and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 44,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues in-order imem requests, queues returned
// words with their PCs, and discards stale responses after a redirect.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               fdwrite,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out
);
  localparam int OW = $clog2(MAX_OUT+1);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = CW + 1;

  logic [PC_W-1:0] fetch_pc, resp_pc;
  logic [OW-1:0]   outstanding, drop_cnt;
  logic [CW-1:0]   occ;
  logic            req_fire, accept, pop;
  fetch_entry_t    head, wentry;

  // Reserving queue space per in-flight request is what keeps the FIFO from overflowing.
  assign imem_req_valid = ~rst & ~redirect_valid &
                          ((SW'(occ) + SW'(outstanding)) < SW'(DEPTH)) &
                          (outstanding < OW'(MAX_OUT));
  assign imem_addr = fetch_pc;
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign accept    = imem_resp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign pop       = fetch_valid & fdwrite & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case ({req_fire, imem_resp_valid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= outstanding - OW'(imem_resp_valid);
      end else begin
        if (req_fire) fetch_pc <= next_pc(fetch_pc);
        if (accept)   resp_pc  <= next_pc(resp_pc);
        if (imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  assign wentry.pc    = resp_pc;
  assign wentry.instr = imem_resp_data;

  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (accept),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (occ)
  );

  assign fetch_valid = ~rst & (occ != '0);
  assign instr_out   = fetch_valid ? head.instr : NOP;
  assign pc_out      = fetch_valid ? head.pc    : '0;
endmodule
